// File: rtl/srl_tap.sv
`default_nettype none
// ============================================================================
//  Module   : srl_tap
//  Purpose  : Per-bit shift register with a runtime tap select (delay 1..DEPTH),
//             parallel valid line, fill counter, primed flag, optional out reg.
//  Revision : 1.0  initial release
// ============================================================================
module srl_tap #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int OREG   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [WIDTH-1:0]  din,
    input  logic              din_vld,
    input  logic [ADDR_W-1:0] tap,
    output logic [WIDTH-1:0]  dout,
    output logic              dout_vld,
    output logic              primed,
    output logic [ADDR_W:0]   fill_cnt
);

    localparam logic [ADDR_W:0]   c_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_LAST  = ADDR_W'(DEPTH-1);
    localparam logic [ADDR_W:0]   c_ONE   = (ADDR_W+1)'(1);

    if (DEPTH < 2 || DEPTH > 32) begin : g_bad_depth
        $error("srl_tap: DEPTH must be in 2..32");
    end
    if ((2 ** ADDR_W) < DEPTH) begin : g_bad_addr
        $error("srl_tap: ADDR_W too narrow for DEPTH");
    end

    // Data array carries no reset so it maps onto SRL primitives; stale
    // contents after rst are hidden by the cleared valid line.
    logic [WIDTH-1:0]  r_stage [DEPTH] = '{default: '0};
    logic [DEPTH-1:0]  r_vld;
    logic [ADDR_W:0]   r_fill;

    logic [ADDR_W-1:0] w_tap_eff;
    logic              w_sel_vld;
    logic [WIDTH-1:0]  w_sel_data;
    logic [WIDTH-1:0]  w_dout;

    always_ff @(posedge clk) begin
        if (ce) begin
            r_stage[0] <= din;
            for (int k = 1; k < DEPTH; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld  <= '0;
            r_fill <= '0;
        end else if (ce) begin
            r_vld <= {r_vld[DEPTH-2:0], din_vld};
            if (r_fill < c_DEPTH) begin
                r_fill <= r_fill + c_ONE;
            end
        end
    end

    // Out-of-range taps read the last stage rather than an undefined one.
    assign w_tap_eff  = ({1'b0, tap} >= c_DEPTH) ? c_LAST : tap;
    assign w_sel_vld  = r_vld[w_tap_eff];
    assign w_sel_data = r_stage[w_tap_eff];
    assign w_dout     = w_sel_vld ? w_sel_data : '0;

    assign primed   = (r_fill > {1'b0, tap});
    assign fill_cnt = r_fill;

    if (OREG != 0) begin : g_oreg
        logic [WIDTH-1:0] r_dout;
        logic             r_dout_vld;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_dout     <= '0;
                r_dout_vld <= 1'b0;
            end else begin
                r_dout     <= w_dout;
                r_dout_vld <= w_sel_vld;
            end
        end

        assign dout     = r_dout;
        assign dout_vld = r_dout_vld;
    end else begin : g_comb
        assign dout     = w_dout;
        assign dout_vld = w_sel_vld;
    end

    a_tap_range: assert property (@(posedge clk) disable iff (rst)
        ({1'b0, tap} < c_DEPTH));

endmodule
`default_nettype wire

// File: tb/tb_srl_tap.sv
`default_nettype none
// ============================================================================
//  Module   : tb_srl_tap
//  Purpose  : Checks srl_tap (OREG=0 and OREG=1 side by side) against a
//             sample-history reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_srl_tap;

    localparam int c_WIDTH = 32;
    localparam int c_DEPTH = 32;
    localparam int c_AW    = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ce  = 1'b0;
    logic [c_WIDTH-1:0] din = '0;
    logic              din_vld = 1'b0;
    logic [c_AW-1:0]   tap = '0;

    logic [c_WIDTH-1:0] dout0, dout1;
    logic              dout_vld0, dout_vld1, primed0, primed1;
    logic [c_AW:0]     fill0, fill1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    srl_tap #(.WIDTH(c_WIDTH), .DEPTH(c_DEPTH), .ADDR_W(c_AW), .OREG(0)) u_dut0 (
        .clk(clk), .rst(rst), .ce(ce), .din(din), .din_vld(din_vld), .tap(tap),
        .dout(dout0), .dout_vld(dout_vld0), .primed(primed0), .fill_cnt(fill0)
    );

    srl_tap #(.WIDTH(c_WIDTH), .DEPTH(c_DEPTH), .ADDR_W(c_AW), .OREG(1)) u_dut1 (
        .clk(clk), .rst(rst), .ce(ce), .din(din), .din_vld(din_vld), .tap(tap),
        .dout(dout1), .dout_vld(dout_vld1), .primed(primed1), .fill_cnt(fill1)
    );

    // Reference model: newest accepted sample at index 0.
    typedef struct {
        logic [c_WIDTH-1:0] d;
        bit                 v;
    } samp_t;

    samp_t              hist[$];
    int                 accepted = 0;
    logic [c_WIDTH-1:0] m_reg_d = '0;
    bit                 m_reg_v = 1'b0;

    function automatic void model_out(input int t, output logic [c_WIDTH-1:0] d, output bit v);
        d = '0;
        v = 1'b0;
        if (t < hist.size() && hist[t].v) begin
            d = hist[t].d;
            v = 1'b1;
        end
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc(input bit r, input bit c, input logic [c_WIDTH-1:0] d,
                       input bit v, input int t, input bit chk);
        logic [c_WIDTH-1:0] ed;
        bit                 ev;
        int                 fc;
        @(negedge clk);
        rst     = r;
        ce      = c;
        din     = d;
        din_vld = v;
        tap     = c_AW'(t);
        #1;
        model_out(t, ed, ev);
        fc = (accepted < c_DEPTH) ? accepted : c_DEPTH;
        if (chk) begin
            check("dout0",     64'(dout0),     64'(ed));
            check("dout_vld0", 64'(dout_vld0), 64'(ev));
            check("primed0",   64'(primed0),   64'(fc > t));
            check("fill0",     64'(fill0),     64'(fc));
            check("dout1",     64'(dout1),     64'(m_reg_d));
            check("dout_vld1", 64'(dout_vld1), 64'(m_reg_v));
            check("primed1",   64'(primed1),   64'(fc > t));
            check("fill1",     64'(fill1),     64'(fc));
        end
        @(posedge clk);
        if (r) begin
            m_reg_d = '0;
            m_reg_v = 1'b0;
            foreach (hist[i]) hist[i].v = 1'b0;
            accepted = 0;
        end else begin
            m_reg_d = ed;
            m_reg_v = ev;
            if (c) begin
                hist.push_front('{d, v});
                if (hist.size() > c_DEPTH) void'(hist.pop_back());
                accepted++;
            end
        end
    endtask

    task automatic stream_from_one(input int n, input int t);
        for (int i = 1; i <= n; i++) cyc(1'b0, 1'b1, c_WIDTH'(i), 1'b1, t, 1'b1);
    endtask

    initial begin
        int dv;
        // Initial reset; outputs are undefined before it, so no checks yet.
        cyc(1'b1, 1'b0, '0, 1'b0, 0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0, 0, 1'b1);

        // tap=0 stream 1,2,3...
        stream_from_one(10, 0);

        // tap=31 long stream, fill_cnt saturates
        cyc(1'b1, 1'b0, '0, 1'b0, 31, 1'b1);
        stream_from_one(45, 31);

        // tap=3 with alternating ce
        cyc(1'b1, 1'b0, '0, 1'b0, 3, 1'b1);
        dv = 10;
        for (int i = 0; i < 24; i++) begin
            cyc(1'b0, (i % 2) == 0, c_WIDTH'(dv), 1'b1, 3, 1'b1);
            if (i % 2 == 0) dv++;
        end

        // tap change mid-stream
        cyc(1'b1, 1'b0, '0, 1'b0, 7, 1'b1);
        stream_from_one(12, 7);
        for (int i = 13; i <= 20; i++) cyc(1'b0, 1'b1, c_WIDTH'(i), 1'b1, 2, 1'b1);

        // reset after 20 samples, then fresh stream
        cyc(1'b1, 1'b0, '0, 1'b0, 0, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b0, 0, 1'b1);
        stream_from_one(6, 0);

        // bubble at tap=0 and tap=5
        for (int t = 0; t <= 5; t += 5) begin
            cyc(1'b1, 1'b0, '0, 1'b0, t, 1'b1);
            for (int i = 0; i < 14; i++) begin
                cyc(1'b0, 1'b1, c_WIDTH'(32'h100 + i), (i != 3), t, 1'b1);
            end
            cyc(1'b1, 1'b1, 32'hDEAD, 1'b1, t, 1'b1);
            cyc(1'b0, 1'b0, '0, 1'b0, t, 1'b1);
        end

        // Random traffic with occasional resets, including rst with ce
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), c_WIDTH'($urandom),
                ($urandom_range(0, 4) != 0), int'($urandom_range(0, c_DEPTH-1)), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
